program_loader: RTL

Boot-time loader that sits directly upstream of the single-cycle processor's instruction memory. It holds the processor in reset and accepts a byte stream over a valid/ready handshake. It packs the bytes little-endian into 32-bit instruction words and writes them sequentially from byte address 0. When the last word is written, it releases the processor to run.

---
 rtl/loader_pkg.sv | 25 ++
 rtl/program_loader_if.sv | 23 ++
 rtl/program_loader_word_packer.sv | 61 ++++++
 rtl/program_loader.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// The loader FSM state encoding is also visible on the top-level debug output.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    DATA  = 3'd3,
    FLUSH = 3'd4,
    RUN   = 3'd5
  } state_t;

  localparam int LEN_BYTES      = 2;
  localparam int LEN_BITS       = 8 * LEN_BYTES;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_BITS      = 8 * BYTES_PER_WORD;

  // A program must contain at least one word and must fit in instruction memory.
  function automatic logic length_ok(input logic [LEN_BITS-1:0] n,
                                     input int unsigned max_words);
    return (n != '0) && (32'(n) <= max_words);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// Handshake: a byte moves on a rising edge where rx_valid && rx_ready; the source
// holds rx_data stable while rx_valid is high and may drop rx_valid between bytes.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/program_loader_word_packer.sv
// Packs bytes little-endian into 32-bit words; word_valid pulses for one cycle
// after the 4th byte and word_data then holds that word until the next one.
module word_packer
  import loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_in,
  output logic                 lane_last,
  output logic                 word_valid,
  output logic [WORD_BITS-1:0] word_data
);

  logic [1:0]             cnt_q,   cnt_d;
  logic [WORD_BITS-9:0]   lanes_q, lanes_d;
  logic [WORD_BITS-1:0]   word_q,  word_d;
  logic                   valid_q, valid_d;

  always_comb begin
    cnt_d   = cnt_q;
    lanes_d = lanes_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear) begin
      cnt_d   = '0;
      lanes_d = '0;
    end else if (byte_valid) begin
      if (cnt_q == 2'(BYTES_PER_WORD - 1)) begin
        word_d  = {byte_in, lanes_q};
        valid_d = 1'b1;
        cnt_d   = '0;
        lanes_d = '0;
      end else begin
        // Newest byte enters at the top so byte 0 ends up in the low lane.
        lanes_d = {byte_in, lanes_q[WORD_BITS-9:8]};
        cnt_d   = cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      lanes_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      lanes_q <= lanes_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign lane_last  = (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word_valid = valid_q;
  assign word_data  = word_q;

endmodule

// File: rtl/program_loader.sv
// Boot loader: holds the CPU in reset, streams a length-prefixed program into
// instruction memory from address 0, then releases the CPU.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  program_loader_if.slave  bus,
  output logic             cpu_reset,
  output logic             done,
  output logic             error,
  output state_t           state_dbg
);

  localparam int IDX_W = $clog2(MAX_WORDS) + 1;

  state_t                state_q,     state_d;
  logic [LEN_BITS-1:0]   len_q,       len_d;
  logic [IDX_W-1:0]      idx_q,       idx_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  done_q,      done_d;
  logic                  error_q,     error_d;

  logic                  rx_fire;
  logic [LEN_BITS-1:0]   len_full;
  logic                  len_legal;
  logic                  pack_clear;
  logic                  pack_byte;
  logic                  lane_last;
  logic                  word_fire;
  logic                  last_word;
  logic                  pack_valid;
  logic [WORD_BITS-1:0]  pack_word;

  assign bus.rx_ready = (state_q == LEN0) || (state_q == LEN1) || (state_q == DATA);
  assign rx_fire      = bus.rx_valid && bus.rx_ready;
  assign len_full     = {bus.rx_data, len_q[7:0]};
  assign len_legal    = length_ok(len_full, MAX_WORDS);
  assign pack_clear   = (state_q == LEN1) && rx_fire && len_legal;
  assign pack_byte    = (state_q == DATA) && rx_fire;
  assign word_fire    = pack_byte && lane_last;
  assign last_word    = (LEN_BITS'(idx_q) + LEN_BITS'(1)) == len_q;

  word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pack_clear),
    .byte_valid (pack_byte),
    .byte_in    (bus.rx_data),
    .lane_last  (lane_last),
    .word_valid (pack_valid),
    .word_data  (pack_word)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    error_d     = error_q;
    case (state_q)
      IDLE, RUN: begin
        if (start) begin
          state_d     = LEN0;
          cpu_reset_d = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
        end
      end
      LEN0: begin
        if (rx_fire) begin
          len_d   = {8'h00, bus.rx_data};
          state_d = LEN1;
        end
      end
      LEN1: begin
        if (rx_fire) begin
          len_d = len_full;
          if (len_legal) begin
            idx_d   = '0;
            state_d = DATA;
          end else begin
            error_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (word_fire) begin
          // Address is latched alongside the packer's word so both appear with imem_we.
          addr_d = ADDR_WIDTH'({idx_q, 2'b00});
          idx_d  = idx_q + IDX_W'(1);
          if (last_word) state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d     = RUN;
        cpu_reset_d = 1'b0;
        done_d      = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.imem_we    = pack_valid;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = pack_word;
  assign cpu_reset      = cpu_reset_q;
  assign done           = done_q;
  assign error          = error_q;
  assign state_dbg      = state_q;

endmodule
